// File: rtl/dma_arb_pkg.sv
// Shared types and host-RAM access for the multi-channel DMA memory arbiter.
//   MAX_CH      upper bound on channels; sizes the channel tag in pipeline entries
//   rd_pipe_t   read-pipeline entry {valid, chan, data}
//   read_ram    host RAM read  (64-bit address in, 64-bit word out)
//   write_ram   host RAM write (64-bit address, 64-bit word)
//   widen_addr  zero-extend / mask a requester address to the 64-bit host address
// read_ram/write_ram operate on an in-package associative-array model RAM.
package dma_arb_pkg;

    localparam int unsigned MAX_CH   = 8;
    localparam int unsigned CH_IDX_W = $clog2(MAX_CH);
    localparam int unsigned HOST_W   = 64;

    typedef struct packed {
        logic                valid;
        logic [CH_IDX_W-1:0] chan;
        logic [HOST_W-1:0]   data;
    } rd_pipe_t;

    // Sparse model RAM; unwritten words read as zero.
    longint unsigned host_ram [longint unsigned];

    function automatic longint unsigned read_ram(input longint unsigned addr);
        if (host_ram.exists(addr)) begin
            return host_ram[addr];
        end
        return 64'd0;
    endfunction

    function automatic void write_ram(input longint unsigned addr, input longint unsigned data);
        host_ram[addr] = data;
    endfunction

    // Keep only the low addr_w bits of an already zero-extended address.
    function automatic logic [HOST_W-1:0] widen_addr(input logic [HOST_W-1:0] addr,
                                                      input int unsigned     addr_w);
        logic [HOST_W-1:0] mask;
        mask = (addr_w >= HOST_W) ? '1 : ((HOST_W'(1) << addr_w) - HOST_W'(1));
        return addr & mask;
    endfunction

endpackage

// File: rtl/dma_mem_arbiter_rr_arbiter.sv
// Round-robin arbiter: picks the first requesting channel at or after ptr+1 (mod NUM_CH).
//   req_i        per-channel request vector
//   ptr_i        index of the previous winner
//   gnt_c_o      one-hot grant (combinational)
//   gnt_idx_c_o  index of the granted channel (combinational)
//   gnt_any_c_o  a grant was issued (combinational)
module rr_arbiter #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned IDX_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [IDX_W-1:0]  ptr_i,
    output logic [NUM_CH-1:0] gnt_c_o,
    output logic [IDX_W-1:0]  gnt_idx_c_o,
    output logic              gnt_any_c_o
);

    // Walk the ring starting one past the last winner; first hit wins.
    always_comb begin
        gnt_c_o     = '0;
        gnt_idx_c_o = '0;
        gnt_any_c_o = 1'b0;
        for (int unsigned off = 1; off <= NUM_CH; off++) begin
            if (!gnt_any_c_o && req_i[IDX_W'((32'(ptr_i) + off) % NUM_CH)]) begin
                gnt_any_c_o = 1'b1;
                gnt_idx_c_o = IDX_W'((32'(ptr_i) + off) % NUM_CH);
                gnt_c_o[IDX_W'((32'(ptr_i) + off) % NUM_CH)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_mem_arbiter.sv
// Multi-channel DMA front end: round-robin arbitration of NUM_CH requesters onto the
// host RAM, one access per cycle, with read data returned on an RD_LAT-deep tagged pipeline.
//   clk, rst       clock; synchronous active-low reset
//   req_valid_i    per-channel request valid
//   req_ready_o    one-hot grant (combinational from req_valid_i and the RR pointer)
//   req_we_i       1 = write, 0 = read
//   req_addr_i     channel c at [c*ADDR_W +: ADDR_W]
//   req_wdata_i    write data, same packing
//   req_wstrb_i    byte enables (only with DMA_ARB_WSTRB_EN)
//   rsp_valid_o    one-cycle read-data pulse per channel
//   rsp_rdata_o    per-channel read data; slices hold their last value
//   busy_o         any read in flight
// Macro DMA_ARB_WSTRB_EN: adds req_wstrb_i and byte-merged writes
//   (read, merge, write in the grant cycle; an all-zero strobe writes nothing).
module dma_mem_arbiter
    import dma_arb_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned ADDR_W = 48,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned RD_LAT = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          req_valid_i,
    output logic [NUM_CH-1:0]          req_ready_o,
    input  logic [NUM_CH-1:0]          req_we_i,
    input  logic [NUM_CH*ADDR_W-1:0]   req_addr_i,
    input  logic [NUM_CH*DATA_W-1:0]   req_wdata_i,
`ifdef DMA_ARB_WSTRB_EN
    input  logic [NUM_CH*DATA_W/8-1:0] req_wstrb_i,
`endif
    output logic [NUM_CH-1:0]          rsp_valid_o,
    output logic [NUM_CH*DATA_W-1:0]   rsp_rdata_o,
    output logic                       busy_o
);

    localparam int unsigned IDX_W  = $clog2(NUM_CH);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic [IDX_W-1:0]  ptr_q;
    logic [NUM_CH-1:0] gnt;
    logic [IDX_W-1:0]  gnt_idx;
    logic              gnt_any;

    logic [ADDR_W-1:0] addr_a  [NUM_CH];
    logic [DATA_W-1:0] wdata_a [NUM_CH];
    logic [DATA_W-1:0] rsp_data_a [NUM_CH];
    logic [DATA_W-1:0] rsp_hold_q [NUM_CH];

    logic              sel_we;
    logic [DATA_W-1:0] sel_wdata;
    logic [HOST_W-1:0] haddr;

    rd_pipe_t pipe_q [RD_LAT];

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_rr_arbiter (
        .req_i       (req_valid_i),
        .ptr_i       (ptr_q),
        .gnt_c_o     (gnt),
        .gnt_idx_c_o (gnt_idx),
        .gnt_any_c_o (gnt_any)
    );

    // No grant is visible while reset is asserted.
    assign req_ready_o = gnt & {NUM_CH{rst}};

    // Per-channel unpacking and response packing.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign addr_a[c]  = req_addr_i[c*ADDR_W +: ADDR_W];
        assign wdata_a[c] = req_wdata_i[c*DATA_W +: DATA_W];
        assign rsp_valid_o[c] = pipe_q[RD_LAT-1].valid
                              && (pipe_q[RD_LAT-1].chan == CH_IDX_W'(c));
        assign rsp_data_a[c]  = rsp_valid_o[c] ? DATA_W'(pipe_q[RD_LAT-1].data) : rsp_hold_q[c];
        assign rsp_rdata_o[c*DATA_W +: DATA_W] = rsp_data_a[c];
    end

    // Selected request fields.
    always_comb begin
        sel_we    = req_we_i[gnt_idx];
        sel_wdata = wdata_a[gnt_idx];
        haddr     = widen_addr(HOST_W'(addr_a[gnt_idx]), ADDR_W);
    end

`ifdef DMA_ARB_WSTRB_EN
    logic [STRB_W-1:0] strb_a [NUM_CH];
    logic [STRB_W-1:0] sel_wstrb;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_strb
        assign strb_a[c] = req_wstrb_i[c*STRB_W +: STRB_W];
    end
    assign sel_wstrb = strb_a[gnt_idx];

    function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                      input logic [DATA_W-1:0] new_w,
                                                      input logic [STRB_W-1:0] strb);
        logic [DATA_W-1:0] m;
        m = old_w;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) begin
                m[b*8 +: 8] = new_w[b*8 +: 8];
            end
        end
        return m;
    endfunction
`endif

    // Pointer, host-RAM access and read pipeline; all RAM calls happen only on a grant edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q <= IDX_W'(NUM_CH - 1);
            for (int s = 0; s < RD_LAT; s++) begin
                pipe_q[s] <= '0;
            end
            for (int c = 0; c < NUM_CH; c++) begin
                rsp_hold_q[c] <= '0;
            end
        end else begin
            if (gnt_any) begin
                ptr_q <= gnt_idx;
                if (sel_we) begin
`ifdef DMA_ARB_WSTRB_EN
                    if (sel_wstrb != '0) begin
                        write_ram(haddr, HOST_W'(merge_bytes(DATA_W'(read_ram(haddr)),
                                                             sel_wdata, sel_wstrb)));
                    end
`else
                    write_ram(haddr, HOST_W'(sel_wdata));
`endif
                end
            end
            if (gnt_any && !sel_we) begin
                pipe_q[0].valid <= 1'b1;
                pipe_q[0].chan  <= CH_IDX_W'(gnt_idx);
                pipe_q[0].data  <= HOST_W'(DATA_W'(read_ram(haddr)));
            end else begin
                pipe_q[0] <= '0;
            end
            for (int s = 1; s < RD_LAT; s++) begin
                pipe_q[s] <= pipe_q[s-1];
            end
            for (int c = 0; c < NUM_CH; c++) begin
                rsp_hold_q[c] <= rsp_data_a[c];
            end
        end
    end

    // Any stage holding a read means a response is still owed.
    always_comb begin
        busy_o = 1'b0;
        for (int s = 0; s < RD_LAT; s++) begin
            busy_o = busy_o | pipe_q[s].valid;
        end
    end

endmodule

// File: tb/tb_dma_mem_arbiter.sv
// Self-checking bench for dma_mem_arbiter: directed scenarios plus randomized traffic,
// compared cycle by cycle against a transaction-level model (grant rule, memory map,
// queue of responses keyed by due cycle).
module tb_dma_mem_arbiter;
    import dma_arb_pkg::*;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned ADDR_W = 48;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned RD_LAT = 2;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned CW     = NUM_CH * DATA_W;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [NUM_CH-1:0]          req_valid, req_ready, req_we, rsp_valid;
    logic [NUM_CH*ADDR_W-1:0]   req_addr;
    logic [NUM_CH*DATA_W-1:0]   req_wdata, rsp_rdata;
`ifdef DMA_ARB_WSTRB_EN
    logic [NUM_CH*STRB_W-1:0]   req_wstrb;
`endif
    logic                       busy;

    always #5 clk = ~clk;

    dma_mem_arbiter #(
        .NUM_CH (NUM_CH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
`ifdef DMA_ARB_WSTRB_EN
        .req_wstrb_i (req_wstrb),
`endif
        .rsp_valid_o (rsp_valid),
        .rsp_rdata_o (rsp_rdata),
        .busy_o      (busy)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic chk(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Requester-side state: a posted request stays up until it is granted.
    logic [NUM_CH-1:0] p_v, p_we;
    logic [ADDR_W-1:0] p_addr  [NUM_CH];
    logic [DATA_W-1:0] p_wdata [NUM_CH];
    logic [STRB_W-1:0] p_strb  [NUM_CH];
    logic              rst_drv;
    logic [NUM_CH-1:0] seen_ready;

    // Reference model.
    longint unsigned mem_m [longint unsigned];
    int              last_g;
    typedef struct {
        int                due;
        int                ch;
        logic [DATA_W-1:0] data;
    } exp_rsp_t;
    exp_rsp_t          rq[$];
    logic [DATA_W-1:0] shown [NUM_CH];

    function automatic logic [DATA_W-1:0] mem_rd(input longint unsigned a);
        return mem_m.exists(a) ? DATA_W'(mem_m[a]) : '0;
    endfunction

    task automatic preload(input longint unsigned a, input longint unsigned d);
        mem_m[a] = d;
        write_ram(a, d);
    endtask

    task automatic post(input int c, input logic we, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] wd, input logic [STRB_W-1:0] st);
        p_v[c] = 1'b1; p_we[c] = we; p_addr[c] = a; p_wdata[c] = wd; p_strb[c] = st;
    endtask

    // One clock cycle: drive, check outputs against the model, then advance the model.
    task automatic cycle();
        logic [NUM_CH-1:0] e_rv, e_gnt;
        logic [CW-1:0]     e_rd;
        logic              e_busy;
        exp_rsp_t          keep[$];
        int                g, best, d;
        longint unsigned   a;
        logic [DATA_W-1:0] mask;
        @(negedge clk);
        rst = rst_drv;
        for (int c = 0; c < NUM_CH; c++) begin
            req_valid[c] = p_v[c];
            req_we[c]    = p_we[c];
            req_addr[c*ADDR_W +: ADDR_W]  = p_addr[c];
            req_wdata[c*DATA_W +: DATA_W] = p_wdata[c];
`ifdef DMA_ARB_WSTRB_EN
            req_wstrb[c*STRB_W +: STRB_W] = p_strb[c];
`endif
        end
        #1;
        e_rv = '0; e_busy = 1'b0;
        foreach (rq[i]) begin
            if (rq[i].due >= cyc) e_busy = 1'b1;
            if (rq[i].due == cyc) begin
                e_rv[rq[i].ch] = 1'b1;
                shown[rq[i].ch] = rq[i].data;
            end else begin
                keep.push_back(rq[i]);
            end
        end
        rq = keep;
        for (int c = 0; c < NUM_CH; c++) e_rd[c*DATA_W +: DATA_W] = shown[c];
        chk("rsp_valid", CW'(rsp_valid), CW'(e_rv));
        chk("rsp_rdata", rsp_rdata, e_rd);
        chk("busy", CW'(busy), CW'(e_busy));

        // Winner: requester the fewest rotation steps past the previous winner.
        g = -1; best = NUM_CH;
        if (rst_drv) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (p_v[c]) begin
                    d = (c - last_g - 1 + 2*NUM_CH) % NUM_CH;
                    if (d < best) begin best = d; g = c; end
                end
            end
        end
        e_gnt = '0;
        if (g >= 0) e_gnt[g] = 1'b1;
        seen_ready = req_ready;
        chk("req_ready", CW'(req_ready), CW'(e_gnt));

        if (g >= 0) begin
            a = 64'(p_addr[g]);
            if (p_we[g]) begin
`ifdef DMA_ARB_WSTRB_EN
                if (p_strb[g] != '0) begin
                    mask = '0;
                    for (int b = 0; b < STRB_W; b++) if (p_strb[g][b]) mask[b*8 +: 8] = 8'hFF;
                    mem_m[a] = 64'((mem_rd(a) & ~mask) | (p_wdata[g] & mask));
                end
`else
                mask = '0;
                mem_m[a] = 64'(p_wdata[g] | mask);
`endif
            end else begin
                rq.push_back('{cyc + RD_LAT, g, mem_rd(a)});
            end
            last_g = g;
            p_v[g] = 1'b0;
        end
        if (!rst_drv) begin
            last_g = NUM_CH - 1;
            rq.delete();
            for (int c = 0; c < NUM_CH; c++) shown[c] = '0;
        end
        cyc++;
    endtask

    initial begin
        rst = 1'b0; rst_drv = 1'b0;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
`ifdef DMA_ARB_WSTRB_EN
        req_wstrb = '0;
`endif
        p_v = '0; p_we = '0; last_g = NUM_CH - 1; seen_ready = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            p_addr[c] = '0; p_wdata[c] = '0; p_strb[c] = '0; shown[c] = '0;
        end
        repeat (2) @(posedge clk);
        cycle();                                    // reset state

        // Single read, fixed latency.
        rst_drv = 1'b1;
        preload(64'h100, 64'hDEAD_BEEF);
        post(0, 1'b0, 48'h100, '0, '0);
        repeat (4) cycle();

        // All channels reading continuously: strict rotation from a fresh pointer.
        rst_drv = 1'b0; cycle(); rst_drv = 1'b1;
        for (int c = 0; c < NUM_CH; c++) preload(64'h200 + 64'(c*8), 64'hC0DE_0000 + 64'(c));
        for (int i = 0; i < 8; i++) begin
            for (int c = 0; c < NUM_CH; c++) if (!p_v[c]) post(c, 1'b0, 48'h200 + 48'(c*8), '0, '0);
            cycle();
            chk("rotation", CW'(seen_ready), CW'(4'b0001 << (i % NUM_CH)));
        end
        p_v = '0;
        repeat (RD_LAT + 1) cycle();

        // Write then read-after-write from another channel; then a same-cycle contest.
        post(1, 1'b1, 48'h40, 64'h55, '1);
        cycle();
        post(2, 1'b0, 48'h40, '0, '0);
        cycle();
        post(1, 1'b0, 48'h40, '0, '0);
        post(2, 1'b0, 48'h100, '0, '0);
        repeat (RD_LAT + 3) cycle();

        // Reset with reads in flight.
        preload(64'h300, 64'h1234_5678_9ABC_DEF0);
        post(0, 1'b0, 48'h300, '0, '0);
        post(1, 1'b0, 48'h300, '0, '0);
        post(2, 1'b0, 48'h300, '0, '0);
        repeat (3) cycle();
        rst_drv = 1'b0; cycle(); rst_drv = 1'b1;
        repeat (RD_LAT + 2) cycle();

        // High address bits survive widening.
        preload(64'h0000_FFFF_0000_0040, 64'hFEED_FACE_CAFE_F00D);
        post(1, 1'b0, 48'hFFFF_0000_0040, '0, '0);
        repeat (RD_LAT + 2) cycle();

`ifdef DMA_ARB_WSTRB_EN
        // Byte-merged write, and an all-zero strobe that must not write.
        preload(64'h8, 64'h1111_2222_3333_4444);
        post(0, 1'b1, 48'h8, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F);
        cycle();
        post(0, 1'b1, 48'h8, 64'h5555_5555_5555_5555, 8'h00);
        cycle();
        post(0, 1'b0, 48'h8, '0, '0);
        repeat (RD_LAT + 2) cycle();
        chk("wstrb_merge", CW'(rsp_rdata[DATA_W-1:0]), CW'(64'h1111_2222_AAAA_AAAA));
`endif

        // Lone requester is granted every cycle.
        for (int i = 0; i < 5; i++) begin
            if (!p_v[3]) post(3, 1'b0, 48'h200, '0, '0);
            cycle();
            chk("lone_ch3", CW'(seen_ready), CW'(4'b1000));
        end
        repeat (RD_LAT + 1) cycle();

        // Randomized traffic over a small address window, with occasional resets.
        for (int i = 0; i < 800; i++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (!p_v[c] && $urandom_range(0, 99) < 45) begin
                    post(c, 1'($urandom_range(0, 1)), 48'($urandom_range(0, 15) * 8),
                         {$urandom, $urandom},
                         ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom));
                end
            end
            rst_drv = ($urandom_range(0, 79) != 0);
            cycle();
        end
        rst_drv = 1'b1;
        p_v = '0;
        repeat (RD_LAT + 2) cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
